// File: rtl/buffer_matriz.sv
// Double-buffered 7x5 LED matrix row store.
// The writer fills the back bank one row at a time while the scanner shows the
// front bank; a requested swap is deferred until the scanner wraps from row 6
// to row 0, so a frame is never torn mid-scan.
module buffer_matriz (
  input  logic       displayClock,
  input  logic       reset,
  input  logic       escreve,
  input  logic [2:0] endereco,
  input  logic [4:0] dado,
  input  logic       troca,
  input  logic [2:0] contagem,
  output logic       pronto,
  output logic       pendente,
  output logic       erro,
  output logic [4:0] linha0,
  output logic [4:0] linha1,
  output logic [4:0] linha2,
  output logic [4:0] linha3,
  output logic [4:0] linha4,
  output logic [4:0] linha5,
  output logic [4:0] linha6
);

  typedef enum logic {LIVRE, ESPERA} state_t;

  state_t     state_q;
  logic       sel_q;
  logic       erro_q;
  logic       erro_d;
  logic [2:0] prev_q;
  logic [4:0] bankA_q [7];
  logic [4:0] bankB_q [7];

  logic       boundary;
  logic       writeOk;

  // Only the wrap from the last row back to the first marks a frame edge.
  assign boundary = (prev_q == 3'd6) && (contagem == 3'd0);

  // Writes are only taken while no swap is waiting, so the back bank is
  // stable from the moment a swap is requested until it happens.
  assign writeOk = escreve && pronto && (endereco != 3'd7);
  assign erro_d  = escreve && pronto && (endereco == 3'd7);

  assign pendente = (state_q == ESPERA);
  assign pronto   = ~pendente;
  assign erro     = erro_q;

  // Front bank straight out of the registers: sel_q=0 shows bank A.
  assign linha0 = sel_q ? bankB_q[0] : bankA_q[0];
  assign linha1 = sel_q ? bankB_q[1] : bankA_q[1];
  assign linha2 = sel_q ? bankB_q[2] : bankA_q[2];
  assign linha3 = sel_q ? bankB_q[3] : bankA_q[3];
  assign linha4 = sel_q ? bankB_q[4] : bankA_q[4];
  assign linha5 = sel_q ? bankB_q[5] : bankA_q[5];
  assign linha6 = sel_q ? bankB_q[6] : bankA_q[6];

  // Swap control: request latches in LIVRE, bank select flips on the frame edge.
  always_ff @(posedge displayClock) begin
    if (reset) begin
      state_q <= LIVRE;
      sel_q   <= 1'b0;
      erro_q  <= 1'b0;
      prev_q  <= 3'd0;
    end else begin
      prev_q <= contagem;
      erro_q <= erro_d;
      case (state_q)
        LIVRE: begin
          if (troca) begin
            state_q <= ESPERA;
          end
        end
        ESPERA: begin
          if (boundary) begin
            state_q <= LIVRE;
            sel_q   <= ~sel_q;
          end
        end
        default: state_q <= LIVRE;
      endcase
    end
  end

  // Row storage: an accepted write always lands in whichever bank is hidden.
  always_ff @(posedge displayClock) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        bankA_q[i] <= 5'b00000;
        bankB_q[i] <= 5'b00000;
      end
    end else if (writeOk) begin
      if (sel_q) begin
        bankA_q[endereco] <= dado;
      end else begin
        bankB_q[endereco] <= dado;
      end
    end
  end

endmodule

// File: tb/tb_buffer_matriz.sv
// Directed bench for buffer_matriz: a vector table walks through reset,
// fill-and-swap, bad address, blocked writes and non-boundary scan counts;
// hand-written sequences cover reset in the middle of a pending swap.
module tb_buffer_matriz;

  logic       displayClock;
  logic       reset;
  logic       escreve;
  logic [2:0] endereco;
  logic [4:0] dado;
  logic       troca;
  logic [2:0] contagem;
  logic       pronto;
  logic       pendente;
  logic       erro;
  logic [4:0] linha0, linha1, linha2, linha3, linha4, linha5, linha6;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        esc;
    logic [2:0]  addr;
    logic [4:0]  data;
    logic        swp;
    logic [2:0]  cnt;
    logic        expPend;
    logic        expErro;
    logic [34:0] expFrame;
  } vec_t;

  vec_t vecs[$];

  // Frames packed as {linha6, ..., linha0}.
  localparam logic [34:0] FZ  = 35'd0;
  localparam logic [34:0] FP  = {5'b11111, 5'b10001, 5'b10001, 5'b10001,
                                 5'b10001, 5'b10001, 5'b11111};
  localparam logic [34:0] FP3 = {5'b11111, 5'b10001, 5'b10001, 5'b01110,
                                 5'b10001, 5'b10001, 5'b11111};
  localparam logic [34:0] FQ  = {5'b11111, 5'b10001, 5'b10001, 5'b01110,
                                 5'b10001, 5'b10001, 5'b00111};

  buffer_matriz dut (
    .displayClock(displayClock),
    .reset(reset),
    .escreve(escreve),
    .endereco(endereco),
    .dado(dado),
    .troca(troca),
    .contagem(contagem),
    .pronto(pronto),
    .pendente(pendente),
    .erro(erro),
    .linha0(linha0),
    .linha1(linha1),
    .linha2(linha2),
    .linha3(linha3),
    .linha4(linha4),
    .linha5(linha5),
    .linha6(linha6)
  );

  // Free-running display clock, 10 time units per cycle.
  initial begin
    displayClock = 1'b0;
    forever #5 displayClock = ~displayClock;
  end

  function automatic logic [34:0] frame();
    return {linha6, linha5, linha4, linha3, linha2, linha1, linha0};
  endfunction

  task automatic addVec(input logic rst, input logic esc, input logic [2:0] addr,
                        input logic [4:0] data, input logic swp, input logic [2:0] cnt,
                        input logic expPend, input logic expErro,
                        input logic [34:0] expFrame);
    vec_t v;
    v.rst = rst; v.esc = esc; v.addr = addr; v.data = data; v.swp = swp;
    v.cnt = cnt; v.expPend = expPend; v.expErro = expErro; v.expFrame = expFrame;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, settle before checking.
  task automatic applyStimulus(input logic rst, input logic esc, input logic [2:0] addr,
                               input logic [4:0] data, input logic swp,
                               input logic [2:0] cnt);
    reset    = rst;
    escreve  = esc;
    endereco = addr;
    dado     = data;
    troca    = swp;
    contagem = cnt;
    @(posedge displayClock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expPend,
                             input logic expErro, input logic [34:0] expFrame);
    checks++;
    if (pendente !== expPend) begin
      errors++;
      $display("[TB] FAIL %s pendente: got %b expected %b", name, pendente, expPend);
    end
    checks++;
    if (pronto !== ~expPend) begin
      errors++;
      $display("[TB] FAIL %s pronto: got %b expected %b", name, pronto, ~expPend);
    end
    checks++;
    if (erro !== expErro) begin
      errors++;
      $display("[TB] FAIL %s erro: got %b expected %b", name, erro, expErro);
    end
    checks++;
    if (frame() !== expFrame) begin
      errors++;
      $display("[TB] FAIL %s linhas: got %h expected %h", name, frame(), expFrame);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    escreve  = 1'b0;
    endereco = 3'd0;
    dado     = 5'd0;
    troca    = 1'b0;
    contagem = 3'd0;

    //     rst esc addr dado      swp cnt  pend erro frame
    // Reset held two cycles, then idle.
    addVec(1, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FZ);
    addVec(1, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FZ);
    // Fill the back bank with a hollow box; the front stays blank.
    addVec(0, 1, 3'd0, 5'b11111, 0, 3'd0, 0, 0, FZ);
    addVec(0, 1, 3'd1, 5'b10001, 0, 3'd0, 0, 0, FZ);
    addVec(0, 1, 3'd2, 5'b10001, 0, 3'd0, 0, 0, FZ);
    addVec(0, 1, 3'd3, 5'b10001, 0, 3'd0, 0, 0, FZ);
    addVec(0, 1, 3'd4, 5'b10001, 0, 3'd0, 0, 0, FZ);
    addVec(0, 1, 3'd5, 5'b10001, 0, 3'd0, 0, 0, FZ);
    addVec(0, 1, 3'd6, 5'b11111, 0, 3'd0, 0, 0, FZ);
    // Request a swap, scan 1..6 then wrap to 0.
    addVec(0, 0, 3'd0, 5'b00000, 1, 3'd0, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd1, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd2, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd3, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd4, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd5, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FP);
    // Address 7 rejected: one-cycle erro pulse.
    addVec(0, 1, 3'd7, 5'b11111, 0, 3'd0, 0, 1, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FP);
    // Swap pending: write blocked silently; scan counts that are not 6->0.
    addVec(0, 0, 3'd0, 5'b00000, 1, 3'd0, 1, 0, FP);
    addVec(0, 1, 3'd3, 5'b10101, 0, 3'd1, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd5, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd7, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd3, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 1, 0, FP);
    // Real wrap: bank A comes back blank (blocked and bad writes left no trace).
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 1, 0, FP);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FZ);
    // Rewrite row 3 of the box bank and bring it back to the front.
    addVec(0, 1, 3'd3, 5'b01110, 0, 3'd0, 0, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 1, 3'd0, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FP3);
    // troca on a boundary while idle: only arms, swap waits for the next wrap.
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 0, 0, FP3);
    addVec(0, 0, 3'd0, 5'b00000, 1, 3'd0, 1, 0, FP3);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 1, 0, FP3);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FZ);
    // Write and troca together: both take effect on the same edge.
    addVec(0, 1, 3'd0, 5'b00111, 1, 3'd0, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd6, 1, 0, FZ);
    addVec(0, 0, 3'd0, 5'b00000, 0, 3'd0, 0, 0, FQ);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].esc, vecs[i].addr, vecs[i].data,
                    vecs[i].swp, vecs[i].cnt);
      checkOutput($sformatf("vec%0d", i), vecs[i].expPend, vecs[i].expErro,
                  vecs[i].expFrame);
    end

    // Reset during a pending swap at count 6 (with a write and troca also
    // presented) cancels everything; the following 0 is not a boundary.
    applyStimulus(0, 0, 3'd0, 5'b00000, 1, 3'd5);
    checkOutput("midrst_arm", 1'b1, 1'b0, FQ);
    applyStimulus(1, 1, 3'd2, 5'b11111, 1, 3'd6);
    checkOutput("midrst_rst", 1'b0, 1'b0, FZ);
    applyStimulus(0, 0, 3'd0, 5'b00000, 0, 3'd0);
    checkOutput("midrst_after", 1'b0, 1'b0, FZ);

    // Swapping afterwards must show that the other bank was cleared too.
    applyStimulus(0, 0, 3'd0, 5'b00000, 1, 3'd0);
    checkOutput("clr_arm", 1'b1, 1'b0, FZ);
    applyStimulus(0, 0, 3'd0, 5'b00000, 0, 3'd6);
    checkOutput("clr_six", 1'b1, 1'b0, FZ);
    applyStimulus(0, 0, 3'd0, 5'b00000, 0, 3'd0);
    checkOutput("clr_swap", 1'b0, 1'b0, FZ);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
